// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, registered
// instruction hand-off to decode with stall and redirect handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter logic [31:0] COUNT_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        enable,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic        discard;
    logic        discard_nxt;
    logic        capture;
    logic        accept;

    assign opcode = instr[6:0];

    always_comb begin
        capture = (state == WAIT) && imem_rvalid
                  && !discard && !redirect;
        accept  = instr_valid && !stall && !redirect;

        pc_nxt = pc;
        if (redirect) begin
            pc_nxt = redirect_pc & 32'hFFFF_FFFC;
        end else if (capture) begin
            pc_nxt = pc + 32'd4;
        end

        state_nxt   = state;
        discard_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = enable ? REQ : IDLE;
            end
            REQ: begin
                // The request is already on the bus; only its reply can be dropped.
                state_nxt   = WAIT;
                discard_nxt = redirect;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (capture) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = enable ? REQ : IDLE;
                    end
                end else begin
                    discard_nxt = discard | redirect;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_nxt = enable ? REQ : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            discard     <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_pc    <= 32'h0000_0000;
            instr_valid <= 1'b0;
            instr_count <= COUNT_INIT;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            discard  <= discard_nxt;
            imem_req <= (state_nxt == REQ);
            if (state_nxt == REQ) begin
                imem_addr <= pc_nxt;
            end
            if (capture) begin
                instr       <= imem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
            end else if (redirect || accept) begin
                instr       <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
            if (accept) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, value driven on instr while no valid instruction is present (addi x0,x0,0).
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: arst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: enable  in  1  fetch permitted when 1.
REQ-006 Port: stall  in  1  decode cannot accept instr this cycle.
REQ-007 Port: redirect  in  1  taken branch/jump; 1-cycle pulse.
REQ-008 Port: redirect_pc  in  32  target address for redirect.
REQ-009 Port: imem_req  out  1  single-cycle read request to instruction memory.
REQ-010 Port: imem_addr  out  32  word-aligned read address, valid while imem_req=1.
REQ-011 Port: imem_rvalid  in  1  read data valid, 1+ cycles after imem_req.
REQ-012 Port: imem_rdata  in  32  instruction word.
REQ-013 Port: instr  out  32  registered instruction to decode.
REQ-014 Port: opcode  out  7  equals instr[6:0] at all times; feeds control decode.
REQ-015 Port: instr_pc  out  32  address of instr.
REQ-016 Port: instr_valid  out  1  instr holds a valid, unconsumed instruction.
REQ-017 Port: instr_count  out  32  number of accepted instructions, wraps modulo 2^32.

Function
REQ-018 FSM states IDLE, REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-019 IDLE: imem_req=0; next REQ when enable=1, else stay.
REQ-020 REQ: imem_req=1, imem_addr=pc for exactly one cycle; next WAIT.
REQ-021 WAIT: imem_req=0; on imem_rvalid=1 with discard=0: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (wraps 32'hFFFF_FFFC->0).
REQ-022 WAIT exit on captured data: next HOLD; on imem_rvalid=0: stay WAIT.
REQ-023 Acceptance = cycle with instr_valid=1 and stall=0; on acceptance instr_valid<=0, instr<=NOP_INSTR, instr_count<=instr_count+1.
REQ-024 HOLD: instr, instr_pc, instr_valid stable while stall=1; on acceptance next REQ if enable=1, else IDLE.
REQ-025 Minimum throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with 1-cycle memory latency and stall=0.
REQ-026 redirect has priority over all other events in every state: pc<=redirect_pc with bits [1:0] forced to 0, instr_valid<=0, instr<=NOP_INSTR, no instr_count increment for an instruction discarded by redirect.
REQ-027 redirect in REQ state: request still issued this cycle, discard<=1, next WAIT.
REQ-028 redirect in WAIT with imem_rvalid=0: discard<=1, stay WAIT; with imem_rvalid=1: response dropped, next REQ.
REQ-029 redirect in IDLE or HOLD: next REQ if enable=1, else IDLE.
REQ-030 WAIT with discard=1 and imem_rvalid=1: response dropped, discard<=0, pc unchanged, next REQ (or IDLE if enable=0).
REQ-031 enable=0: no new request issued; outstanding request completes per REQ-021/030; HOLD content retained until accepted.
REQ-032 imem_rvalid outside WAIT is ignored.

Reset
REQ-033 arst_n=0 asynchronously forces: state IDLE, pc=RESET_PC, discard=0, imem_req=0, imem_addr=RESET_PC, instr=NOP_INSTR, opcode=7'b0010011, instr_pc=0, instr_valid=0, instr_count=0.
REQ-034 Reset mid-request: outstanding transaction abandoned; a later imem_rvalid in IDLE is ignored.
REQ-035 First imem_req occurs no earlier than the first clk edge after arst_n deasserts with enable=1.

Verification
REQ-036 Reset release, enable=1, 1-cycle memory returning 32'h0000_0033 at 0 -> imem_req at addr 0, instr=32'h0000_0033, opcode=7'b0110011, instr_pc=0, instr_valid=1 on 3rd cycle.
REQ-037 stall=1 for 5 cycles while instr_valid=1 -> instr/instr_pc constant, no imem_req; stall=0 -> instr_count+1, next imem_req at addr 4.
REQ-038 redirect=1, redirect_pc=32'h0000_0103 during WAIT, rvalid 2 cycles later -> response dropped, instr_valid stays 0, next imem_req addr 32'h0000_0100.
REQ-039 redirect coincident with imem_rvalid -> data never appears on instr, next imem_req addr=redirect target.
REQ-040 pc=32'hFFFF_FFFC fetch accepted -> next imem_addr=0; instr_count preset near 32'hFFFF_FFFF wraps to 0.
REQ-041 arst_n pulsed low during WAIT -> all outputs to REQ-033 values immediately; stray imem_rvalid ignored.
